// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Game-level sequencer around the pong physics block. Runs the
//            IDLE -> SERVE -> PLAY -> POINT -> OVER flow, owns the physics
//            reset/enable and serve direction, detects goals once per frame
//            from ball_pos_x and keeps both players' scores.
// Ports    : clk_25MHz   - system clock
//            reset       - synchronous active-high reset
//            vert_blank  - vertical blank level (rising edge = frame tick)
//            start       - start button level (rising edge used)
//            pause       - freezes play while high
//            ball_pos_x  - ball x position from physics
//            phys_reset  - physics reset (ball/paddles held at home)
//            phys_enable - physics update gate
//            serve_dir   - 0 = serve toward player0, 1 = toward player1
//            score0/1    - player scores
//            game_over   - high while in OVER
//            winner      - 0 = player0 won, 1 = player1 won
//            state       - IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned GOAL_MARGIN  = 2,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       vert_blank,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] ball_pos_x,
  output logic       phys_reset,
  output logic       phys_enable,
  output logic       serve_dir,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [9:0] GOAL_LEFT  = 10'(GOAL_MARGIN);
  localparam logic [9:0] GOAL_RIGHT = 10'(SCREEN_W - BALL_SIZE - GOAL_MARGIN);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

  state_e     state_q,      state_d;
  logic [7:0] frame_cnt_q,  frame_cnt_d;
  logic [3:0] score0_q,     score0_d;
  logic [3:0] score1_q,     score1_d;
  logic       serve_dir_q,  serve_dir_d;
  logic       game_over_q,  game_over_d;
  logic       winner_q,     winner_d;
  logic       phys_reset_q, phys_reset_d;
  logic       vb_q;
  logic       st_q;

  logic       frame_tick;
  logic       start_edge;
  logic [3:0] scorer_score;

  assign frame_tick = vert_blank & ~vb_q;
  assign start_edge = start & ~st_q;

  // In POINT the serve direction already encodes who scored: a serve toward
  // player1 (1) means player0 took the point.
  assign scorer_score = serve_dir_q ? score0_q : score1_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          score0_d    = 4'd0;
          score1_d    = 4'd0;
          serve_dir_d = 1'b0;
          game_over_d = 1'b0;
          frame_cnt_d = 8'd0;
          state_d     = S_SERVE;
        end
      end

      S_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q == SERVE_LAST) begin
            frame_cnt_d = 8'd0;
            state_d     = S_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      S_PLAY: begin
        if (frame_tick && !pause) begin
          // Left goal checked first so a misconfigured overlap resolves
          // deterministically in player1's favour.
          if (ball_pos_x <= GOAL_LEFT) begin
            score1_d    = (score1_q == WIN_VAL) ? score1_q : score1_q + 4'd1;
            serve_dir_d = 1'b0;
            state_d     = S_POINT;
          end else if (ball_pos_x >= GOAL_RIGHT) begin
            score0_d    = (score0_q == WIN_VAL) ? score0_q : score0_q + 4'd1;
            serve_dir_d = 1'b1;
            state_d     = S_POINT;
          end
        end
      end

      S_POINT: begin
        frame_cnt_d = 8'd0;
        if (scorer_score == WIN_VAL) begin
          winner_d    = ~serve_dir_q;
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          state_d     = S_SERVE;
        end
      end

      S_OVER: begin
        if (frame_tick) begin
          if (frame_cnt_q == OVER_LAST) begin
            frame_cnt_d = 8'd0;
            game_over_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        // Unreachable encodings recover to IDLE.
        frame_cnt_d = 8'd0;
        game_over_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Physics runs only in PLAY; registering against the entered state keeps
    // phys_reset aligned with the state output.
    phys_reset_d = (state_d != S_PLAY);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= 8'd0;
      score0_q     <= 4'd0;
      score1_q     <= 4'd0;
      serve_dir_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      phys_reset_q <= 1'b1;
      vb_q         <= 1'b0;
      st_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      serve_dir_q  <= serve_dir_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      phys_reset_q <= phys_reset_d;
      vb_q         <= vert_blank;
      st_q         <= start;
    end
  end

  assign phys_reset  = phys_reset_q;
  assign phys_enable = (state_q == S_PLAY) & ~pause;
  assign serve_dir   = serve_dir_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Self-checking bench for pong_game_ctrl. A behavioural game model
//            tracks the expected outputs every cycle while directed scenarios
//            and randomized frames drive the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

  localparam int SERVE_N = 60;
  localparam int OVER_N  = 180;
  localparam int WIN_N   = 7;
  localparam int LEFT_X  = 2;
  localparam int RIGHT_X = 640 - 8 - 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       vert_blank;
  logic       start;
  logic       pause;
  logic [9:0] ball_pos_x;
  logic       phys_reset;
  logic       phys_enable;
  logic       serve_dir;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  always #20 clk = ~clk;

  pong_game_ctrl dut (
    .clk_25MHz  (clk),
    .reset      (reset),
    .vert_blank (vert_blank),
    .start      (start),
    .pause      (pause),
    .ball_pos_x (ball_pos_x),
    .phys_reset (phys_reset),
    .phys_enable(phys_enable),
    .serve_dir  (serve_dir),
    .score0     (score0),
    .score1     (score1),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural game model: phase names, ticks seen in the current phase,
  // score totals and the last input levels for edge detection.
  int m_phase;
  int m_ticks;
  int m_s0, m_s1;
  int m_dir, m_over, m_win;
  bit m_vb, m_st;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, sedge;
    tick  = vert_blank && !m_vb;
    sedge = start && !m_st;
    m_vb  = vert_blank;
    m_st  = start;
    if (reset) begin
      m_phase = 0; m_ticks = 0; m_s0 = 0; m_s1 = 0;
      m_dir = 0; m_over = 0; m_win = 0; m_vb = 0; m_st = 0;
      return;
    end
    case (m_phase)
      0: if (sedge) begin
           m_s0 = 0; m_s1 = 0; m_dir = 0; m_over = 0; m_ticks = 0; m_phase = 1;
         end
      1: if (tick) begin
           m_ticks++;
           if (m_ticks == SERVE_N) begin m_ticks = 0; m_phase = 2; end
         end
      2: if (tick && !pause) begin
           if (int'(ball_pos_x) <= LEFT_X) begin
             if (m_s1 < WIN_N) m_s1++;
             m_dir = 0; m_phase = 3;
           end else if (int'(ball_pos_x) >= RIGHT_X) begin
             if (m_s0 < WIN_N) m_s0++;
             m_dir = 1; m_phase = 3;
           end
         end
      3: begin
           m_ticks = 0;
           // player0 is the scorer when the next serve heads right
           if ((m_dir == 1 ? m_s0 : m_s1) == WIN_N) begin
             m_win = (m_dir == 1) ? 0 : 1; m_over = 1; m_phase = 4;
           end else begin
             m_phase = 1;
           end
         end
      4: if (tick) begin
           m_ticks++;
           if (m_ticks == OVER_N) begin m_ticks = 0; m_over = 0; m_phase = 0; end
         end
      default: m_phase = 0;
    endcase
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_val("state",       32'(state),       32'(m_phase));
    check_val("phys_reset",  32'(phys_reset),  32'(m_phase != 2));
    check_val("phys_enable", 32'(phys_enable), 32'(m_phase == 2 && !pause));
    check_val("serve_dir",   32'(serve_dir),   32'(m_dir));
    check_val("score0",      32'(score0),      32'(m_s0));
    check_val("score1",      32'(score1),      32'(m_s1));
    check_val("game_over",   32'(game_over),   32'(m_over));
    check_val("winner",      32'(winner),      32'(m_win));
  endtask

  task automatic frame(input int hi, input int lo);
    vert_blank = 1'b1;
    repeat (hi) cyc();
    vert_blank = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic serve_to_play();
    ball_pos_x = 10'd320;
    repeat (SERVE_N) frame(1, 3);
  endtask

  // Scores a point for player0 (right goal) or player1 (left goal).
  task automatic goal(input bit right);
    ball_pos_x = right ? 10'(RIGHT_X) : 10'(LEFT_X);
    frame(1, 3);
  endtask

  initial begin
    reset = 1'b1; vert_blank = 1'b0; start = 1'b0; pause = 1'b0; ball_pos_x = 10'd320;

    // 1. reset and start
    repeat (3) cyc();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_score0", 32'(score0), 32'd0);
    reset = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    check_val("start_serve", 32'(state), 32'd1);
    start = 1'b0;
    serve_to_play();
    check_val("serve_done", 32'(state), 32'd2);
    check_val("play_enable", 32'(phys_enable), 32'd1);

    // 2. goals and near misses
    ball_pos_x = 10'd2;
    vert_blank = 1'b1;
    cyc();
    check_val("lgoal_point", 32'(state), 32'd3);
    check_val("lgoal_score1", 32'(score1), 32'd1);
    vert_blank = 1'b0;
    cyc();
    check_val("lgoal_serve", 32'(state), 32'd1);
    cyc(); cyc();
    serve_to_play();
    ball_pos_x = 10'd629; frame(1, 3);
    ball_pos_x = 10'd3;   frame(1, 3);
    check_val("near_miss", 32'(state), 32'd2);
    goal(1'b1);
    check_val("rgoal_score0", 32'(score0), 32'd1);
    check_val("rgoal_dir", 32'(serve_dir), 32'd1);
    serve_to_play();

    // 3. no tick, no goal; long vblank counts once
    ball_pos_x = 10'd0;
    repeat (1000) cyc();
    check_val("notick_score1", 32'(score1), 32'd1);
    frame(1, 3);
    check_val("tick_goal", 32'(score1), 32'd2);
    ball_pos_x = 10'd320;
    frame(50, 3);
    repeat (SERVE_N - 1) frame(1, 3);
    check_val("long_vb_once", 32'(state), 32'd2);

    // 4. pause
    pause = 1'b1; ball_pos_x = 10'd0;
    repeat (5) frame(1, 3);
    check_val("pause_en", 32'(phys_enable), 32'd0);
    check_val("pause_state", 32'(state), 32'd2);
    pause = 1'b0;
    frame(1, 3);
    check_val("unpause_goal", 32'(score1), 32'd3);
    serve_to_play();

    // 5. game end with start held through OVER
    repeat (5) begin goal(1'b1); serve_to_play(); end
    ball_pos_x = 10'd631; start = 1'b1;
    vert_blank = 1'b1;
    cyc();
    check_val("win_point", 32'(state), 32'd3);
    check_val("win_score0", 32'(score0), 32'd7);
    cyc();
    check_val("win_over", 32'(game_over), 32'd1);
    check_val("win_who", 32'(winner), 32'd0);
    vert_blank = 1'b0; cyc(); cyc();
    repeat (OVER_N) frame(1, 3);
    repeat (10) cyc();
    check_val("over_idle", 32'(state), 32'd0);
    check_val("over_hold", 32'(score0), 32'd7);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    start = 1'b0;
    check_val("restart", 32'(state), 32'd1);
    serve_to_play();

    // 6. reset mid-game at 3:5
    repeat (3) begin goal(1'b1); serve_to_play(); end
    repeat (5) begin goal(1'b0); serve_to_play(); end
    check_val("pre_rst_s1", 32'(score1), 32'd5);
    reset = 1'b1;
    cyc();
    check_val("midrst_state", 32'(state), 32'd0);
    check_val("midrst_score1", 32'(score1), 32'd0);
    reset = 1'b0;
    cyc();

    // Randomized frames; every cycle is checked against the model.
    for (int f = 0; f < 3000; f++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10)      ball_pos_x = 10'($urandom_range(0, 4));
      else if (r < 20) ball_pos_x = 10'($urandom_range(627, 640));
      else             ball_pos_x = 10'($urandom_range(5, 626));
      pause = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 499) == 0);
      vert_blank = 1'b1;
      repeat (int'($urandom_range(1, 3))) begin
        cyc();
        reset = 1'b0;
        start = ($urandom_range(0, 3) == 0);
      end
      vert_blank = 1'b0;
      repeat (int'($urandom_range(1, 3))) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-level sequencer that wraps the physics block. It owns the physics reset and enable controls and the serve direction. It detects goals from ball_pos_x once per frame, keeps both players' scores, and runs the IDLE -> SERVE -> PLAY -> POINT -> OVER flow. It sits between the input/button logic and the physics block, and its scores and state feed the VGA overlay.

Parameters:
SCREEN_W, 640, visible width in pixels
BALL_SIZE, 8, ball width in pixels
GOAL_MARGIN, 2, distance in pixels from the screen edge at which a goal is declared
WIN_SCORE, 7, score that ends the game (must be 1..15)
SERVE_FRAMES, 60, frames the ball is held at centre before play (must be 1..255)
OVER_FRAMES, 180, frames the game-over state is shown before returning to IDLE (must be 1..255)

Ports:
clk_25MHz  in   1   system clock
reset      in   1   synchronous, active-high reset
vert_blank in   1   vertical blank level; its rising edge is the frame tick
start      in   1   start button level (debounced upstream); its rising edge is used
pause      in   1   level; freezes play while high
ball_pos_x in   10  ball x from physics, updated at vblank
phys_reset out  1   drives the physics block reset; holds ball and paddles at home
phys_enable out 1   gates physics updates (ANDed into new_data and vblank)
serve_dir  out  1   next serve direction: 0 = toward player0 (left), 1 = toward player1 (right)
score0     out  4   player0 score
score1     out  4   player1 score
game_over  out  1   high in OVER
winner     out  1   0 = player0 won, 1 = player1 won; valid while game_over is high
state      out  3   IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- One clock (clk_25MHz). Reset is synchronous and active-high and takes priority over every other event, including mid-game.
- Reset values: state=IDLE, phys_reset=1, phys_enable=0, serve_dir=0, score0=0, score1=0, game_over=0, winner=0, frame_cnt=0, vb_q=0, st_q=0.
- Edge detectors:
  - frame_tick = vert_blank & ~vb_q. A vert_blank held high for N cycles gives exactly one tick.
  - start_edge = start & ~st_q.
  - vb_q and st_q are registered every cycle.
- All outputs are registered and are a function of the state being entered. The new value is visible on the cycle after the transition condition.
- IDLE: phys_reset=1, phys_enable=0. Scores hold their last values for display.
  - On start_edge: score0=0, score1=0, serve_dir=0, game_over=0, frame_cnt=0, go to SERVE.
  - frame_tick in the same cycle is ignored.
- SERVE: phys_reset=1, phys_enable=0.
  - Each frame_tick increments frame_cnt.
  - The tick on which frame_cnt==SERVE_FRAMES-1 sets frame_cnt=0 and moves to PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
  - pause does not stall SERVE.
- PLAY: phys_reset=0, phys_enable = ~pause (combinational from the registered state and pause). Goal check runs only on frame_tick with pause=0:
  - ball_pos_x <= GOAL_MARGIN: player1 scores, serve_dir=0.
  - else ball_pos_x >= SCREEN_W-BALL_SIZE-GOAL_MARGIN (630 at defaults): player0 scores, serve_dir=1.
  - The left check has priority if both are true, which is only possible with misconfigured parameters.
  - On a goal, the scorer's score increments and the block goes to POINT.
  - No goal: stay in PLAY.
- POINT: lasts exactly 1 cycle. phys_reset=1, phys_enable=0.
  - If the scorer's updated score == WIN_SCORE: winner=scorer, game_over=1, frame_cnt=0, go to OVER.
  - Otherwise: frame_cnt=0, go to SERVE.
  - Scores never exceed WIN_SCORE (no wrap).
- OVER: phys_reset=1, phys_enable=0, game_over=1.
  - Counts OVER_FRAMES frame ticks, then goes to IDLE with game_over=0. winner and the scores hold.
  - start is ignored in OVER. A start held through OVER does not restart the game in IDLE; a new rising edge is required.
- Illegal state encodings (5..7) return to IDLE on the next cycle with the IDLE output values.

Test Plan:
1. Reset and start: reset for 3 cycles -> state=0, phys_reset=1, phys_enable=0, scores 0. Pulse start -> state=1 on the next cycle. After exactly 60 frame ticks -> state=2, phys_reset=0, phys_enable=1.
2. Goal and serve: in PLAY, ball_pos_x=2 on a tick -> state=3 for 1 cycle, score1=1, serve_dir=0, then state=1. In PLAY, ball_pos_x=630 on a tick -> score0=1, serve_dir=1. ball_pos_x=629 or 3 -> no goal.
3. Tick-only sampling: ball_pos_x=0 with no frame tick for 1000 cycles -> no score change. vert_blank held high for 50 cycles -> exactly one frame_cnt increment.
4. Pause: pause=1 in PLAY with ball_pos_x=0 across 5 ticks -> phys_enable=0, state stays 2, scores unchanged. Release pause -> goal taken on the next tick.
5. Game end: score0 at 6 and ball_pos_x=631 -> score0=7, state 3 then 4, game_over=1, winner=0. After 180 ticks -> state=0, game_over=0, scores held at 7. start held high throughout -> stays IDLE until the next start edge.
6. Reset mid-game: assert reset in PLAY with score0=3 and score1=5 -> next cycle all outputs at reset values, state=0.
